// File: rtl/bus_master_arb_mux_if.sv
// ============================================================================
// Module      : bus_master_arb_mux_if
// Description : Master-side request bundle and slave-side muxed bus for the
//               round-robin master arbiter/mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_master_arb_mux_if #(
  parameter int NUM_MASTERS   = 4,
  parameter int BUS_ADD_WIDTH = 32,
  parameter int BUS_DAT_WIDTH = 32
);
  logic [NUM_MASTERS-1:0]               m_req_i;
  logic [NUM_MASTERS*BUS_ADD_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0]               m_addr_cs_i;
  logic [NUM_MASTERS-1:0]               m_rw_i;
  logic [NUM_MASTERS*BUS_DAT_WIDTH-1:0] m_wr_data_i;
  logic [NUM_MASTERS-1:0]               m_grnt_o;
  logic                                 s_rdy_i;
  logic [BUS_ADD_WIDTH-1:0]             s_addr_o;
  logic                                 s_addr_cs_o;
  logic                                 s_rw_o;
  logic [BUS_DAT_WIDTH-1:0]             s_data_o;
  logic                                 busy_o;

  // Arbiter view: consumes master requests and the slave strobe.
  modport slave (
    input  m_req_i, m_addr_i, m_addr_cs_i, m_rw_i, m_wr_data_i, s_rdy_i,
    output m_grnt_o, s_addr_o, s_addr_cs_o, s_rw_o, s_data_o, busy_o
  );

  // Environment view: drives requests and the slave strobe.
  modport master (
    output m_req_i, m_addr_i, m_addr_cs_i, m_rw_i, m_wr_data_i, s_rdy_i,
    input  m_grnt_o, s_addr_o, s_addr_cs_o, s_rw_o, s_data_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/bus_master_arb_mux.sv
// ============================================================================
// Module      : bus_master_arb_mux
// Description : Round-robin arbiter with registered one-hot grant, hold limit
//               and master-to-slave bus multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_master_arb_mux #(
  parameter int NUM_MASTERS   = 4,
  parameter int BUS_ADD_WIDTH = 32,
  parameter int BUS_DAT_WIDTH = 32,
  parameter int MAX_HOLD      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bus_master_arb_mux_if.slave  bus
);

  localparam int PTR_W  = $clog2(NUM_MASTERS);
  localparam int HOLD_W = $clog2(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [NUM_MASTERS-1:0]  grnt, grnt_nxt;
  logic [PTR_W-1:0]        last, last_nxt;
  logic [HOLD_W-1:0]       hold_cnt, hold_nxt;

  logic                    found;
  logic [PTR_W-1:0]        pick;
  int                      idx;

  logic                    own_req;
  logic                    own_cs;
  logic                    others_req;
  logic                    hold_max;
  logic                    release_bus;

  // Round-robin search starting just after the last owner, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (!found && bus.m_req_i[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  assign own_req     = |(bus.m_req_i & grnt);
  assign own_cs      = |(bus.m_addr_cs_i & grnt);
  assign others_req  = |(bus.m_req_i & ~grnt);
  assign hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  // The hold limit never cuts an access that is still waiting for s_rdy_i.
  assign release_bus = !own_req ||
                       (hold_max && others_req && (!own_cs || bus.s_rdy_i));

  always_comb begin
    state_nxt = state;
    grnt_nxt  = grnt;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grnt_nxt  = NUM_MASTERS'(1) << pick;
          last_nxt  = pick;
          hold_nxt  = '0;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if (release_bus) begin
          grnt_nxt  = '0;
          state_nxt = IDLE;
        end else if (!hold_max) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        grnt_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      grnt     <= '0;
      last     <= PTR_W'(NUM_MASTERS - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grnt     <= grnt_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // AND-OR mux; the grant is one-hot or zero, so all outputs are 0 when idle.
  always_comb begin
    bus.s_addr_o    = '0;
    bus.s_addr_cs_o = 1'b0;
    bus.s_rw_o      = 1'b0;
    bus.s_data_o    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.s_addr_o    = bus.s_addr_o |
                        ({BUS_ADD_WIDTH{grnt[i]}} & bus.m_addr_i[i*BUS_ADD_WIDTH +: BUS_ADD_WIDTH]);
      bus.s_addr_cs_o = bus.s_addr_cs_o | (grnt[i] & bus.m_addr_cs_i[i]);
      bus.s_rw_o      = bus.s_rw_o | (grnt[i] & bus.m_rw_i[i]);
      bus.s_data_o    = bus.s_data_o |
                        ({BUS_DAT_WIDTH{grnt[i]}} & bus.m_wr_data_i[i*BUS_DAT_WIDTH +: BUS_DAT_WIDTH]);
    end
  end

  assign bus.m_grnt_o = grnt;
  assign bus.busy_o   = (state == OWNED);

endmodule

`default_nettype wire

// File: tb/tb_bus_master_arb_mux.sv
// ============================================================================
// Module      : tb_bus_master_arb_mux
// Description : Scoreboard bench for the 4-master (MAX_HOLD=4) and 3-master
//               arbiter/mux instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_master_arb_mux;

  typedef struct {
    int          d;
    logic [3:0]  grant;
    int          start;
    int          len;
    logic [31:0] addr;
    logic        cs;
    logic        rw;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [3:0]   req4 = '0, cs4 = 4'b1111;
  logic [2:0]   req3 = '0, cs3 = 3'b111;
  logic [3:0]   rw4  = 4'b1010;
  logic [2:0]   rw3  = 3'b010;
  logic [127:0] addr4, data4;
  logic [95:0]  addr3, data3;
  logic         rdy = 1'b0;

  exp_t       q[$];
  logic [3:0] prev_g[2] = '{4'b0, 4'b0};
  bit         act[2] = '{1'b0, 1'b0};
  int         act_start[2] = '{0, 0};
  int         cur_len[2] = '{0, 0};

  bus_master_arb_mux_if #(.NUM_MASTERS(4)) bus4();
  bus_master_arb_mux_if #(.NUM_MASTERS(3)) bus3();

  assign bus4.m_req_i     = req4;
  assign bus4.m_addr_i    = addr4;
  assign bus4.m_addr_cs_i = cs4;
  assign bus4.m_rw_i      = rw4;
  assign bus4.m_wr_data_i = data4;
  assign bus4.s_rdy_i     = rdy;
  assign bus3.m_req_i     = req3;
  assign bus3.m_addr_i    = addr3;
  assign bus3.m_addr_cs_i = cs3;
  assign bus3.m_rw_i      = rw3;
  assign bus3.m_wr_data_i = data3;
  assign bus3.s_rdy_i     = rdy;

  bus_master_arb_mux #(.NUM_MASTERS(4), .MAX_HOLD(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4)
  );
  bus_master_arb_mux #(.NUM_MASTERS(3), .MAX_HOLD(16)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] m_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [31:0] m_data(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, a, e);
    end
  endtask

  task automatic push(input int d, input int i, input int start, input int len, input logic cs);
    exp_t e;
    e.d     = d;
    e.grant = 4'b0001 << i;
    e.start = start;
    e.len   = len;
    e.addr  = m_addr(i);
    e.cs    = cs;
    e.rw    = i[0];
    e.data  = m_data(i);
    q.push_back(e);
  endtask

  // Grant-driven monitor: pops one expectation per new grant, checks duration on release.
  task automatic mon(input int d, input logic [3:0] g, input logic [31:0] addr,
                     input logic cs, input logic rw, input logic [31:0] data, input logic busy);
    exp_t e;
    if (g != prev_g[d]) begin
      if (act[d]) begin
        chk("hold_len", 32'(cyc - act_start[d]), 32'(cur_len[d]));
        act[d] = 1'b0;
      end
      if (g != 4'b0) begin
        chk("dead_cycle", {28'b0, prev_g[d]}, 32'b0);
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_grant dut%0d at cycle %0d: got %b, expected none", d, cyc, g);
        end else begin
          e = q.pop_front();
          chk("dut_id", 32'(d), 32'(e.d));
          chk("grant", {28'b0, g}, {28'b0, e.grant});
          chk("grant_cycle", 32'(cyc), 32'(e.start));
          chk("s_addr", addr, e.addr);
          chk("s_cs", {31'b0, cs}, {31'b0, e.cs});
          chk("s_rw", {31'b0, rw}, {31'b0, e.rw});
          chk("s_data", data, e.data);
          act[d]       = 1'b1;
          act_start[d] = cyc;
          cur_len[d]   = e.len;
        end
      end
    end
    chk("busy", {31'b0, busy}, {31'b0, (g != 4'b0)});
    if (g == 4'b0) begin
      chk("idle_addr", addr, 32'b0);
      chk("idle_data", data, 32'b0);
      chk("idle_ctl", {30'b0, cs, rw}, 32'b0);
    end
    prev_g[d] = g;
  endtask

  always @(negedge clk) begin
    mon(0, bus4.m_grnt_o, bus4.s_addr_o, bus4.s_addr_cs_o, bus4.s_rw_o, bus4.s_data_o, bus4.busy_o);
    mon(1, {1'b0, bus3.m_grnt_o}, bus3.s_addr_o, bus3.s_addr_cs_o, bus3.s_rw_o, bus3.s_data_o, bus3.busy_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input int i, input logic v);
    if (d == 0) req4[i] = v;
    else        req3[i] = v;
  endtask

  // One master: on each grant, keep req for 3 grant cycles, drop, re-raise a cycle later.
  task automatic run_master(input int d, input int i, input int grants);
    for (int k = 0; k < grants; k++) begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
        @(negedge clk);
        seen = (d == 0) ? bus4.m_grnt_o[i] : bus3.m_grnt_o[i];
      end
      n_cmp++;
      if (!seen) begin
        n_fail++;
        $display("FAIL grant_timeout dut%0d m%0d: got no grant, expected grant within 200 cycles", d, i);
        return;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      set_req(d, i, 1'b0);
      if (k < grants - 1) begin
        tick();
        set_req(d, i, 1'b1);
      end
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req4 = '0;
    req3 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 4; i++) begin
      addr4[i*32 +: 32] = m_addr(i);
      data4[i*32 +: 32] = m_data(i);
    end
    for (int i = 0; i < 3; i++) begin
      addr3[i*32 +: 32] = m_addr(i);
      data3[i*32 +: 32] = m_data(i);
    end
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_grant", {28'b0, bus4.m_grnt_o}, 32'b0);
    chk("reset_busy", {31'b0, bus4.busy_o}, 32'b0);
    repeat (10) tick();

    // Single request from master 0.
    t0 = cyc;
    req4 = 4'b0001;
    push(0, 0, t0 + 1, 3, 1'b1);
    repeat (3) tick();
    req4 = 4'b0000;
    repeat (3) tick();

    // All four request; round robin 0,1,2,3,0 with one dead cycle between owners.
    do_reset();
    t0 = cyc;
    req4 = 4'b1111;
    push(0, 0, t0 + 1, 3, 1'b1);
    push(0, 1, t0 + 5, 3, 1'b1);
    push(0, 2, t0 + 9, 3, 1'b1);
    push(0, 3, t0 + 13, 3, 1'b1);
    push(0, 0, t0 + 17, 3, 1'b1);
    fork
      run_master(0, 0, 2);
      run_master(0, 1, 1);
      run_master(0, 2, 1);
      run_master(0, 3, 1);
    join
    repeat (3) tick();

    // Hold limit with cs low: m0 loses the bus after 4 grant cycles.
    cs4 = 4'b1010;
    t0 = cyc;
    req4 = 4'b0001;
    push(0, 0, t0 + 1, 4, 1'b0);
    push(0, 2, t0 + 6, 2, 1'b0);
    tick();
    req4[2] = 1'b1;
    repeat (4) tick();
    req4[0] = 1'b0;
    repeat (2) tick();
    req4[2] = 1'b0;
    repeat (3) tick();

    // Hold limit with an access in flight: release only on s_rdy_i.
    cs4 = 4'b1011;
    t0 = cyc;
    req4 = 4'b0001;
    push(0, 0, t0 + 1, 7, 1'b1);
    push(0, 2, t0 + 9, 2, 1'b0);
    tick();
    req4[2] = 1'b1;
    repeat (6) tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    req4[0] = 1'b0;
    repeat (2) tick();
    req4[2] = 1'b0;
    repeat (3) tick();

    // Asynchronous reset between edges while m0 owns the bus.
    t0 = cyc;
    req4 = 4'b0001;
    push(0, 0, t0 + 1, 1, 1'b1);
    tick();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", {28'b0, bus4.m_grnt_o}, 32'b0);
    chk("async_rst_busy", {31'b0, bus4.busy_o}, 32'b0);
    chk("async_rst_addr", bus4.s_addr_o, 32'b0);
    chk("async_rst_cs", {31'b0, bus4.s_addr_cs_o}, 32'b0);
    req4 = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // After reset master 0 beats master 2 again.
    t0 = cyc;
    req4 = 4'b0101;
    push(0, 0, t0 + 1, 1, 1'b1);
    push(0, 2, t0 + 3, 1, 1'b0);
    tick();
    req4[0] = 1'b0;
    repeat (2) tick();
    req4[2] = 1'b0;
    repeat (3) tick();

    // Three-master instance: order 0,1,2,0.
    t0 = cyc;
    req3 = 3'b111;
    push(1, 0, t0 + 1, 3, 1'b1);
    push(1, 1, t0 + 5, 3, 1'b1);
    push(1, 2, t0 + 9, 3, 1'b1);
    push(1, 0, t0 + 13, 3, 1'b1);
    fork
      run_master(1, 0, 2);
      run_master(1, 1, 1);
      run_master(1, 2, 1);
    join
    repeat (4) tick();

    chk("pending_expectations", 32'(q.size()), 32'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/bus_master_arb_mux.md
Name: bus_master_arb_mux

Overview:
- Parametrised successor to the fixed four-master bus multiplexer.
- Integrates a round-robin arbiter with the master-to-slave mux for NUM_MASTERS masters.
- Grants are registered and one-hot. A hold limit bounds how long one master can keep the bus while others are requesting.
- Sits between the CPU-side bus masters (core, DMA, debug) and the shared slave address decoder.

Parameters:
- NUM_MASTERS, 4, number of masters; legal range 2..16.
- BUS_ADD_WIDTH, 32, address width.
- BUS_DAT_WIDTH, 32, write-data width.
- MAX_HOLD, 16, maximum consecutive grant cycles while another master is requesting; legal range 2..256.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- m_req_i  input  NUM_MASTERS  per-master bus request; bit i belongs to master i.
- m_addr_i  input  NUM_MASTERS*BUS_ADD_WIDTH  packed addresses; master i occupies slice [i*BUS_ADD_WIDTH +: BUS_ADD_WIDTH].
- m_addr_cs_i  input  NUM_MASTERS  per-master address chip select.
- m_rw_i  input  NUM_MASTERS  per-master read/write; 1 = read, 0 = write.
- m_wr_data_i  input  NUM_MASTERS*BUS_DAT_WIDTH  packed write data, same slicing rule as m_addr_i.
- m_grnt_o  output  NUM_MASTERS  registered one-hot grant.
- s_rdy_i  input  1  slave completion strobe for the current access.
- s_addr_o  output  BUS_ADD_WIDTH  muxed address.
- s_addr_cs_o  output  1  muxed chip select.
- s_rw_o  output  1  muxed read/write.
- s_data_o  output  BUS_DAT_WIDTH  muxed write data.
- busy_o  output  1  high while any grant is active.

Behaviour:
- Reset (asynchronous, rst_i = 1):
  - state = IDLE, m_grnt_o = 0, busy_o = 0.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 has top priority first.
  - hold_cnt = 0.
  - All s_* outputs = 0.
- Reset mid-transfer drops the grant immediately. No access completes.
- FSM has two states, IDLE and OWNED.
- IDLE:
  - If m_req_i != 0 at a rising edge, grant the first requesting index searching last+1, last+2, … modulo NUM_MASTERS.
  - At that edge: m_grnt_o = one-hot(i), last = i, hold_cnt = 0, state = OWNED.
  - Grant latency is exactly 1 cycle from request sampled.
- OWNED, owner i:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release condition, evaluated each edge:
    - m_req_i[i] = 0, or
    - hold_cnt == MAX_HOLD-1 AND another m_req_i bit is set AND (m_addr_cs_i[i] = 0 OR s_rdy_i = 1).
  - On release: m_grnt_o = 0, state = IDLE.
  - This gives exactly one dead (turnaround) cycle before the next grant. No back-to-back grant to a different master.
  - An access in flight (cs high, no s_rdy_i) is never preempted by the hold limit.
  - An owner dropping m_req_i releases the bus regardless of cs. Masters must not drop req mid-access.
  - If no other master requests, the owner keeps the bus indefinitely. hold_cnt saturates and does not wrap.
- Output mux:
  - s_* outputs are combinational from the registered m_grnt_o and the owner's inputs.
  - All s_* outputs are 0 when m_grnt_o = 0.
  - m_grnt_o is one-hot or zero by construction. No multi-hot state is reachable.
- busy_o = (state == OWNED).
- Simultaneous events:
  - A request from the just-released master in the same cycle as a competitor's request: the competitor wins, because the pointer has advanced.
  - An owner dropping req while s_rdy_i = 1 in the same cycle: release.
- Width rules:
  - Pointer width = clog2(NUM_MASTERS); wrap is modulo NUM_MASTERS for non-power-of-two counts.
  - hold_cnt width = clog2(MAX_HOLD).

Test Plan:
- Reset release, no requests: all outputs 0 for 10 cycles. Then m_req_i = 4'b0001 → m_grnt_o = 4'b0001 the next cycle; s_addr_o = m0 address (e.g. 32'h1000_0000); busy_o = 1.
- All four request continuously, each drops req 3 cycles after its grant:
  - Grant order is 0,1,2,3,0.
  - Exactly one zero-grant cycle between owners.
  - s_* outputs are 0 in the gap cycles.
- Hold limit, MAX_HOLD = 4: m0 holds req with cs = 0 and m2 requests → m0 released after 4 grant cycles, then one idle cycle, then m_grnt_o = 4'b0100.
- Hold limit with an in-flight access: m0 cs = 1 and s_rdy_i held low past MAX_HOLD → grant stays with m0. On the first s_rdy_i = 1 cycle the release occurs, then m2 is granted after the dead cycle.
- Asynchronous reset asserted mid-grant, between clock edges → m_grnt_o, busy_o and s_* go to 0 without waiting for an edge. After release, master 0 has top priority again.
- NUM_MASTERS = 3 instance: requests 3'b111 held with per-grant drops → order 0,1,2,0. Pointer wraps from 2 to 0, never reaching index 3.
